// File: rtl/gerador_jogador.sv
// Player car generator: moves the car one step per frame from the buttons,
// holds a blinking crash state, and draws the 16x32 car sprite one clock late.
module gerador_jogador #(
  parameter int X_MIN         = 192,
  parameter int X_MAX         = 432,
  parameter int X_INICIAL     = 312,
  parameter int Y_CARRO       = 416,
  parameter int PASSO         = 4,
  parameter int FRAMES_BATIDA = 60
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [9:0] x,
  input  logic [8:0] y,
  input  logic       quadro,
  input  logic       esquerda,
  input  logic       direita,
  input  logic       colisao,
  output logic [2:0] jogador,
  output logic [9:0] pos_x,
  output logic       batendo
);

  typedef enum logic {NORMAL = 1'b0, BATIDA = 1'b1} estado_t;

  localparam logic [10:0] X_MIN_L    = 11'(X_MIN);
  localparam logic [10:0] X_MAX_L    = 11'(X_MAX);
  localparam logic [10:0] PASSO_L    = 11'(PASSO);
  localparam logic [9:0]  X_MIN_P    = 10'(X_MIN);
  localparam logic [9:0]  X_MAX_P    = 10'(X_MAX);
  localparam logic [9:0]  X_INI_P    = 10'(X_INICIAL);
  localparam logic [9:0]  PASSO_P    = 10'(PASSO);
  localparam logic [9:0]  Y_CARRO_P  = 10'(Y_CARRO);
  localparam logic [5:0]  ULTIMO_P   = 6'(FRAMES_BATIDA - 1);

  estado_t     estado_r, estado_s;
  logic [9:0]  pos_r, pos_s;
  logic [5:0]  cont_r, cont_s;
  logic [2:0]  jog_r, cor_s;
  logic        bat_r;
  logic [9:0]  esq_s, dir_s;
  logic [10:0] dx_s;
  logic [9:0]  dy_s;
  logic [3:0]  c_s;
  logic [4:0]  r_s;
  logic        dentro_s, lateral_s, pneu_s, janela_s;

  // Clamped candidate positions; compared in 11 bits so a left step never wraps.
  always_comb begin
    esq_s = pos_r;
    dir_s = pos_r;
    if ({1'b0, pos_r} < X_MIN_L + PASSO_L) begin
      esq_s = X_MIN_P;
    end else begin
      esq_s = pos_r - PASSO_P;
    end
    if ({1'b0, pos_r} + PASSO_L > X_MAX_L) begin
      dir_s = X_MAX_P;
    end else begin
      dir_s = pos_r + PASSO_P;
    end
  end

  // Next state, position and crash frame counter.
  always_comb begin
    estado_s = estado_r;
    pos_s    = pos_r;
    cont_s   = cont_r;
    case (estado_r)
      NORMAL: begin
        if (colisao) begin
          estado_s = BATIDA;
          cont_s   = 6'd0;
        end else if (quadro) begin
          if (esquerda && !direita) begin
            pos_s = esq_s;
          end else if (direita && !esquerda) begin
            pos_s = dir_s;
          end else begin
            pos_s = pos_r;
          end
        end else begin
          pos_s = pos_r;
        end
      end
      BATIDA: begin
        if (quadro) begin
          if (cont_r == ULTIMO_P) begin
            estado_s = NORMAL;
            cont_s   = 6'd0;
          end else begin
            cont_s = cont_r + 6'd1;
          end
        end else begin
          cont_s = cont_r;
        end
      end
      default: begin
        estado_s = NORMAL;
        cont_s   = 6'd0;
      end
    endcase
  end

  // Sprite lookup against the current registered position; negative offsets
  // wrap to large unsigned values and fall outside the box.
  always_comb begin
    dx_s      = {1'b0, x} - {1'b0, pos_r};
    dy_s      = {1'b0, y} - Y_CARRO_P;
    c_s       = dx_s[3:0];
    r_s       = dy_s[4:0];
    dentro_s  = (dx_s < 11'd16) && (dy_s < 10'd32);
    lateral_s = (c_s < 4'd2) || (c_s > 4'd13);
    pneu_s    = lateral_s && (((r_s >= 5'd4) && (r_s <= 5'd9)) ||
                              ((r_s >= 5'd22) && (r_s <= 5'd27)));
    janela_s  = (r_s >= 5'd6) && (r_s <= 5'd11) && (c_s >= 4'd4) && (c_s <= 4'd11);
    if (!dentro_s) begin
      cor_s = 3'b111;
    end else if ((estado_r == BATIDA) && cont_r[3]) begin
      cor_s = 3'b111;
    end else if (pneu_s) begin
      cor_s = 3'b000;
    end else if (lateral_s) begin
      cor_s = 3'b111;
    end else if (janela_s) begin
      cor_s = 3'b110;
    end else begin
      cor_s = 3'b101;
    end
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      estado_r <= NORMAL;
      pos_r    <= X_INI_P;
      cont_r   <= 6'd0;
      jog_r    <= 3'b111;
      bat_r    <= 1'b0;
    end else begin
      estado_r <= estado_s;
      pos_r    <= pos_s;
      cont_r   <= cont_s;
      jog_r    <= cor_s;
      bat_r    <= (estado_s == BATIDA);
    end
  end

  assign jogador = jog_r;
  assign pos_x   = pos_r;
  assign batendo = bat_r;

endmodule

// File: tb/tb_gerador_jogador.sv
// Bench for gerador_jogador: directed scenarios plus random stimulus, all
// checked against a frame-level model of the car and its sprite.
module tb_gerador_jogador;

  logic       clk = 1'b0;
  logic       reset, quadro, esquerda, direita, colisao;
  logic [9:0] x;
  logic [8:0] y;
  logic [2:0] jogador, jogador2;
  logic [9:0] pos_x, pos_x2;
  logic       batendo, batendo2;

  int n_vec = 0;
  int n_err = 0;

  int m_pos    = 312;
  bit m_crash  = 1'b0;
  int m_frames = 0;
  int m_jog    = 7;

  always #5 clk = ~clk;

  gerador_jogador dut (
    .clk(clk), .reset(reset), .x(x), .y(y), .quadro(quadro),
    .esquerda(esquerda), .direita(direita), .colisao(colisao),
    .jogador(jogador), .pos_x(pos_x), .batendo(batendo)
  );

  gerador_jogador #(.X_INICIAL(194)) dut2 (
    .clk(clk), .reset(reset), .x(x), .y(y), .quadro(quadro),
    .esquerda(esquerda), .direita(direita), .colisao(colisao),
    .jogador(jogador2), .pos_x(pos_x2), .batendo(batendo2)
  );

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic int sprite(int xi, int yi, int p, bit cr, int fr);
    int  c, r;
    bit  side;
    c = xi - p;
    r = yi - 416;
    if (c < 0 || c > 15 || r < 0 || r > 31) return 7;
    if (cr && ((fr / 8) % 2 == 1)) return 7;
    side = (c < 2) || (c > 13);
    if (side && ((r >= 4 && r <= 9) || (r >= 22 && r <= 27))) return 0;
    if (side) return 7;
    if (r >= 6 && r <= 11 && c >= 4 && c <= 11) return 6;
    return 5;
  endfunction

  // Apply one cycle of inputs, advance the model, compare all outputs.
  task automatic step(input bit r, input int xi, input int yi,
                      input bit q, input bit e, input bit d, input bit c);
    reset = r; x = 10'(xi); y = 9'(yi);
    quadro = q; esquerda = e; direita = d; colisao = c;
    if (r) begin
      m_pos = 312; m_crash = 1'b0; m_frames = 0; m_jog = 7;
    end else begin
      m_jog = sprite(xi, yi, m_pos, m_crash, m_frames);
      if (!m_crash) begin
        if (c) begin
          m_crash = 1'b1; m_frames = 0;
        end else if (q && e && !d) begin
          m_pos = (m_pos - 4 < 192) ? 192 : m_pos - 4;
        end else if (q && d && !e) begin
          m_pos = (m_pos + 4 > 432) ? 432 : m_pos + 4;
        end
      end else if (q) begin
        if (m_frames == 59) begin
          m_crash = 1'b0; m_frames = 0;
        end else begin
          m_frames++;
        end
      end
    end
    @(posedge clk);
    #1;
    chk("model_pos_x", 16'(pos_x), 16'(m_pos));
    chk("model_batendo", 16'(batendo), 16'(m_crash));
    chk("model_jogador", 16'(jogador), 16'(m_jog));
  endtask

  initial begin
    int xi, yi;
    reset = 1'b1; x = '0; y = '0; quadro = 1'b0;
    esquerda = 1'b0; direita = 1'b0; colisao = 1'b0;

    // Reset state and the four reference pixels.
    step(1, 316, 416, 1, 0, 1, 1);
    chk("rst_pos_x", 16'(pos_x), 16'd312);
    chk("rst_batendo", 16'(batendo), 16'd0);
    chk("rst_jogador", 16'(jogador), 16'd7);
    chk("rst_pos_x2", 16'(pos_x2), 16'd194);
    step(0, 312, 416, 0, 0, 0, 0); chk("pix_corner", 16'(jogador), 16'd7);
    step(0, 316, 416, 0, 0, 0, 0); chk("pix_body", 16'(jogador), 16'd5);
    step(0, 312, 420, 0, 0, 0, 0); chk("pix_tire", 16'(jogador), 16'd0);
    step(0, 318, 422, 0, 0, 0, 0); chk("pix_window", 16'(jogador), 16'd6);

    // Left clamp on the second instance, which starts at 194.
    step(0, 0, 0, 1, 1, 0, 0); chk("left_clamp", 16'(pos_x2), 16'd192);
    step(0, 0, 0, 1, 1, 0, 0); chk("left_hold", 16'(pos_x2), 16'd192);

    // Right travel and clamp.
    step(1, 0, 0, 0, 0, 0, 0);
    for (int k = 1; k <= 40; k++) begin
      step(0, 0, 0, 0, 0, 1, 0);
      chk("no_move_midframe", 16'(pos_x), 16'((312 + 4 * (k - 1) > 432) ? 432 : 312 + 4 * (k - 1)));
      step(0, 0, 0, 1, 0, 1, 0);
      chk("right_walk", 16'(pos_x), 16'((312 + 4 * k > 432) ? 432 : 312 + 4 * k));
    end
    step(0, 0, 0, 1, 1, 1, 0); chk("both_buttons", 16'(pos_x), 16'd432);

    // Crash entry with a simultaneous move, blink pattern, exit on 60th frame.
    step(1, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 1, 0, 1, 1);
    chk("crash_batendo", 16'(batendo), 16'd1);
    chk("crash_pos_x", 16'(pos_x), 16'd312);
    for (int f = 0; f < 60; f++) begin
      step(0, 316, 416, 0, 0, 1, f < 59);
      chk("blink", 16'(jogador), 16'(((f / 8) % 2 == 1) ? 7 : 5));
      step(0, 316, 416, 1, 0, 1, f < 59);
      chk("crash_frozen", 16'(pos_x), 16'd312);
      chk("crash_end", 16'(batendo), 16'((f < 59) ? 1 : 0));
    end

    // Reset in the middle of a crash.
    step(0, 0, 0, 1, 0, 1, 0);
    step(0, 0, 0, 0, 0, 0, 1);
    for (int f = 0; f < 30; f++) step(0, 316, 416, 1, 0, 0, 0);
    step(1, 316, 416, 1, 1, 0, 1);
    chk("midcrash_rst_bat", 16'(batendo), 16'd0);
    chk("midcrash_rst_pos", 16'(pos_x), 16'd312);
    chk("midcrash_rst_jog", 16'(jogador), 16'd7);

    // Random traffic.
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 3) != 0) xi = m_pos + int'($urandom_range(0, 23)) - 4;
      else xi = int'($urandom_range(0, 1023));
      if ($urandom_range(0, 3) != 0) yi = 412 + int'($urandom_range(0, 39));
      else yi = int'($urandom_range(0, 511));
      step($urandom_range(0, 499) == 0, xi, yi, $urandom_range(0, 3) == 0,
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           $urandom_range(0, 79) == 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
